// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 Hz timing constants and bounce-window geometry.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL     = 1056;
    localparam int unsigned H_ACT_START = 216;
    localparam int unsigned H_ACT_END   = 1015;

    localparam int unsigned V_TOTAL     = 628;
    localparam int unsigned V_ACT_START = 27;
    localparam int unsigned V_ACT_END   = 626;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned IMG_H   = 128;
    localparam int unsigned X_LIMIT = 672;
    localparam int unsigned Y_LIMIT = 472;

    // Direction of travel along one axis.
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

endpackage

// File: rtl/bounce_axis_module.sv
// One axis of the bouncing window: steps the position once per enabled tick
// and reverses at 0 and LIMIT, clamping so the position never wraps.
module bounce_axis_module #(
    parameter int unsigned STEP  = 2,
    parameter int unsigned LIMIT = 672,
    parameter int unsigned INIT  = 336
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       enable,
    output logic [9:0] pos,
    output logic       dir
);
    import vga_timing_pkg::*;

    localparam logic [9:0] STEP_V  = 10'(STEP);
    localparam logic [9:0] LIMIT_V = 10'(LIMIT);
    localparam logic [9:0] INIT_V  = 10'(INIT);

    logic [9:0] pos_q, pos_d;
    dir_e       dir_q, dir_d;

    // Position/direction state, returns to the start position on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= INIT_V;
            dir_q <= DIR_INC;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // Next position: step toward the current wall, clamp and turn when reached.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick && enable) begin
            if (dir_q == DIR_INC) begin
                if (pos_q + STEP_V >= LIMIT_V) begin
                    pos_d = LIMIT_V;
                    dir_d = DIR_DEC;
                end else begin
                    pos_d = pos_q + STEP_V;
                end
            end else begin
                if (pos_q <= STEP_V) begin
                    pos_d = '0;
                    dir_d = DIR_INC;
                end else begin
                    pos_d = pos_q - STEP_V;
                end
            end
        end
    end

    assign pos = pos_q;
    assign dir = (dir_q == DIR_DEC);

endmodule

// File: rtl/vga_bounce_image_module.sv
// Pixel stage: draws a 128x128 monochrome ROM image in a window that bounces
// around the 800x600 visible area. Fixed 3-clock latency from qC1/qC2 to
// RGB_Sig so the external 3-stage sync delay stays aligned.
module vga_bounce_image_module #(
    parameter int unsigned STEP   = 2,
    parameter int unsigned INIT_X = 336,
    parameter int unsigned INIT_Y = 236,
    parameter logic [2:0]  FG_RGB = 3'b111,
    parameter logic [2:0]  BG_RGB = 3'b001
) (
    input  logic        CLK_40Mhz,
    input  logic        RSTn,
    input  logic [10:0] qC1,
    input  logic [9:0]  qC2,
    input  logic        Move_En,
    output logic [10:0] ROM_Addr,
    input  logic [7:0]  ROM_Data,
    output logic [2:0]  RGB_Sig,
    output logic        Frame_Tick
);
    import vga_timing_pkg::*;

    logic [9:0]  x0, y0;
    logic        dir_x_unused, dir_y_unused;

    logic [10:0] x_vis;
    logic [9:0]  y_vis;
    logic [6:0]  dx, dy;
    logic        in_x, in_y;

    logic [10:0] rom_addr_q, rom_addr_d;
    logic        vis1_q, vis1_d, hit1_q, hit1_d;
    logic [2:0]  bit1_q, bit1_d;
    logic        vis2_q, vis2_d, hit2_q, hit2_d;
    logic [2:0]  bit2_q, bit2_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        frame_tick_q, frame_tick_d;

    bounce_axis_module #(
        .STEP  (STEP),
        .LIMIT (X_LIMIT),
        .INIT  (INIT_X)
    ) u_axis_x (
        .clk    (CLK_40Mhz),
        .rst_n  (RSTn),
        .tick   (frame_tick_q),
        .enable (Move_En),
        .pos    (x0),
        .dir    (dir_x_unused)
    );

    bounce_axis_module #(
        .STEP  (STEP),
        .LIMIT (Y_LIMIT),
        .INIT  (INIT_Y)
    ) u_axis_y (
        .clk    (CLK_40Mhz),
        .rst_n  (RSTn),
        .tick   (frame_tick_q),
        .enable (Move_En),
        .pos    (y0),
        .dir    (dir_y_unused)
    );

    // Stage 1 decode: visibility, window hit and image address from the counters.
    always_comb begin
        x_vis  = qC1 - 11'(H_ACT_START);
        y_vis  = qC2 - 10'(V_ACT_START);
        vis1_d = (qC1 >= 11'(H_ACT_START)) && (qC1 <= 11'(H_ACT_END)) &&
                 (qC2 >= 10'(V_ACT_START)) && (qC2 <= 10'(V_ACT_END));
        in_x   = (x_vis >= {1'b0, x0}) && (x_vis < ({1'b0, x0} + 11'(IMG_W)));
        in_y   = (y_vis >= y0) && (y_vis < (y0 + 10'(IMG_H)));
        // Window offsets are < 128, so 7-bit modular subtraction is exact.
        dx     = x_vis[6:0] - x0[6:0];
        dy     = y_vis[6:0] - y0[6:0];
        hit1_d = vis1_d && in_x && in_y;
        bit1_d = dx[2:0];
        rom_addr_d = hit1_d ? {dy, dx[6:3]} : rom_addr_q;
    end

    // Stages 2-3 and frame-end detect: delay flags past the ROM, then pick the colour.
    always_comb begin
        vis2_d       = vis1_q;
        hit2_d       = hit1_q;
        bit2_d       = bit1_q;
        frame_tick_d = (qC1 == 11'(H_TOTAL - 1)) && (qC2 == 10'(V_TOTAL - 1));
        rgb_d        = '0;
        if (vis2_q) begin
            if (hit2_q && ROM_Data[3'd7 - bit2_q]) begin
                rgb_d = FG_RGB;
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    // Pipeline and frame-tick registers.
    always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
        if (!RSTn) begin
            rom_addr_q   <= '0;
            vis1_q       <= 1'b0;
            hit1_q       <= 1'b0;
            bit1_q       <= '0;
            vis2_q       <= 1'b0;
            hit2_q       <= 1'b0;
            bit2_q       <= '0;
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            vis1_q       <= vis1_d;
            hit1_q       <= hit1_d;
            bit1_q       <= bit1_d;
            vis2_q       <= vis2_d;
            hit2_q       <= hit2_d;
            bit2_q       <= bit2_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ROM_Addr   = rom_addr_q;
    assign RGB_Sig    = rgb_q;
    assign Frame_Tick = frame_tick_q;

endmodule
